// File: rtl/dircc_node_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a node's single-port RAM (one-cycle read latency).
// Define DIRCC_MEM_ARB_LOCK_EN to add mN_lock ports for locked (atomic) access sequences.
module dircc_node_mem_arbiter #(
  parameter int                ADDR_W   = 14,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 10240,
  parameter int                MAX_HOLD = 16,
  parameter logic [DATA_W-1:0] OOR_DATA = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
`ifdef DIRCC_MEM_ARB_LOCK_EN
  input  logic                  m0_lock,
  input  logic                  m1_lock,
`endif
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_clken,
  output logic [DATA_W-1:0]     mem_writedata,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int              BE_W    = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic              req0, req1, allow0, allow1;
  logic              gnt0, gnt1, acc, win;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_wr, in_range;
  logic              last_q, last_d;
  logic              rd_pend_q, rd_pend_d, rd_owner_q, rd_oor_q;
  logic              force_rel, rel_id;
  logic [DATA_W-1:0] rdata;

`ifdef DIRCC_MEM_ARB_LOCK_EN
  typedef enum logic [1:0] {ARB = 2'd0, LOCKED0 = 2'd1, LOCKED1 = 2'd2} state_e;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              sel_lock;

  assign sel_lock = win ? m1_lock : m0_lock;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ARB;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // The forced release fires on the cycle the incremented count reaches MAX_HOLD-1,
  // so the other requester wins the very next cycle.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    force_rel = 1'b0;
    if (state_q != ARB) begin
      hold_d = hold_q + HOLD_W'(1);
      if (hold_d == HOLD_W'(MAX_HOLD - 1)) begin
        force_rel = 1'b1;
        state_d   = ARB;
      end else if (acc && !sel_lock) begin
        state_d = ARB;
      end
    end else if (acc && sel_lock) begin
      state_d = win ? LOCKED1 : LOCKED0;
      hold_d  = '0;
    end
  end

  always_comb begin
    allow0 = (state_q != LOCKED1);
    allow1 = (state_q != LOCKED0);
    rel_id = (state_q == LOCKED1);
  end
`else
  logic unused_cfg;

  assign unused_cfg = (MAX_HOLD > 0);
  assign allow0     = 1'b1;
  assign allow1     = 1'b1;
  assign force_rel  = 1'b0;
  assign rel_id     = 1'b0;
`endif

  // A tie goes to whichever requester was not granted last.
  always_comb begin
    req0 = (m0_read | m0_write) & allow0;
    req1 = (m1_read | m1_write) & allow1;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
    acc       = gnt0 | gnt1;
    win       = gnt1;
    sel_addr  = win ? m1_address   : m0_address;
    sel_be    = win ? m1_byteenable : m0_byteenable;
    sel_wdata = win ? m1_writedata : m0_writedata;
    sel_wr    = win ? m1_write     : m0_write;
    in_range  = ({1'b0, sel_addr} < DEPTH_W);
  end

  always_comb begin
    last_d = last_q;
    if (acc) last_d = win;
    if (force_rel) last_d = rel_id;
    rd_pend_d = acc & ~sel_wr;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q    <= 1'b1;
      rd_pend_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      rd_owner_q <= win;
      rd_oor_q   <= ~in_range;
    end
  end

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  assign mem_address    = sel_addr;
  assign mem_byteenable = sel_be;
  assign mem_writedata  = sel_wdata;
  assign mem_chipselect = acc & in_range;
  assign mem_write      = acc & sel_wr & in_range;
  assign mem_clken      = reset_n;

  // Return path is gated by reset so a read accepted just before reset never reports.
  assign rdata            = rd_oor_q ? OOR_DATA : mem_readdata;
  assign m0_readdata      = reset_n ? rdata : '0;
  assign m1_readdata      = reset_n ? rdata : '0;
  assign m0_readdatavalid = reset_n & rd_pend_q & ~rd_owner_q;
  assign m1_readdatavalid = reset_n & rd_pend_q & rd_owner_q;

endmodule

// File: tb/tb_dircc_node_mem_arbiter.sv
// Scoreboard bench for dircc_node_mem_arbiter with a behavioural byte-enabled RAM model.
// Lock scenario is exercised only when DIRCC_MEM_ARB_LOCK_EN is defined.
module tb_dircc_node_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata;
`ifdef DIRCC_MEM_ARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif

  always #5 clk = ~clk;

  dircc_node_mem_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
`ifdef DIRCC_MEM_ARB_LOCK_EN
    .m0_lock          (m0_lock),
    .m1_lock          (m1_lock),
`endif
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_clken        (mem_clken),
    .mem_writedata    (mem_writedata),
    .mem_readdata     (mem_readdata)
  );

  // RAM model: preloaded on the first edge, one-cycle registered read.
  logic [31:0] ram [0:16383];
  logic        ram_init_done = 1'b0;

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 16384; i++)
        ram[i] <= (i == 5) ? 32'h12345678 : ((i < 64) ? 32'h10000000 + 32'(i) : 32'h0);
      ram_init_done <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_read(input logic owner, input logic [31:0] data);
    exp_q.push_back('{owner: owner, data: data, due: cyc + 1});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_read  = 1'b0;
    m0_write = 1'b0;
    m1_read  = 1'b0;
    m1_write = 1'b0;
`ifdef DIRCC_MEM_ARB_LOCK_EN
    m0_lock = 1'b0;
    m1_lock = 1'b0;
`endif
  endtask

  // Monitor: every readdatavalid pulse must match the oldest expected read, on time.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m0_readdatavalid || m1_readdatavalid) begin
        if (exp_q.size() == 0) begin
          check("rdv_unexpected", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rdv_owner", {30'd0, m1_readdatavalid, m0_readdatavalid}, e.owner ? 32'd2 : 32'd1);
          check("rdv_cycle", cyc, e.due);
          check("rdata", e.owner ? m1_readdata : m0_readdata, e.data);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("rdv_missing", {30'd0, m1_readdatavalid, m0_readdatavalid}, e.owner ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin
    idle_all();
    m0_address = '0; m1_address = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;

    // Requests held during reset are refused and the RAM side is idle.
    reset_n = 1'b0;
    m0_read = 1'b1;
    m1_read = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wait0", m0_waitrequest, 1);
    check("rst_wait1", m1_waitrequest, 1);
    check("rst_rdv0", m0_readdatavalid, 0);
    check("rst_rdv1", m1_readdatavalid, 0);
    check("rst_cs", mem_chipselect, 0);
    check("rst_memwr", mem_write, 0);
    check("rst_clken", mem_clken, 0);
    check("rst_rdata0", m0_readdata, 0);

    // Single read of address 5.
    next_cycle();
    reset_n = 1'b1;
    idle_all();
    m0_read = 1'b1; m0_address = 14'd5;
    @(negedge clk);
    check("t1_wait0", m0_waitrequest, 0);
    check("t1_wait1", m1_waitrequest, 1);
    check("t1_cs", mem_chipselect, 1);
    check("t1_clken", mem_clken, 1);
    expect_read(1'b0, 32'h12345678);
    next_cycle();
    idle_all();
    next_cycle();

    // Partial write by m1, then read-back by m0 on the next cycle.
    m1_write = 1'b1; m1_address = 14'd100; m1_byteenable = 4'b0011; m1_writedata = 32'hA5A5A5A5;
    @(negedge clk);
    check("t3_wr_wait1", m1_waitrequest, 0);
    check("t3_memwr", mem_write, 1);
    check("t3_be", mem_byteenable, 4'b0011);
    next_cycle();
    idle_all();
    m0_read = 1'b1; m0_address = 14'd100;
    @(negedge clk);
    check("t3_rd_wait0", m0_waitrequest, 0);
    expect_read(1'b0, 32'h0000A5A5);
    next_cycle();
    idle_all();
    next_cycle();

    // Out-of-range write is dropped; out-of-range read returns the filler word.
    m0_write = 1'b1; m0_address = 14'd10240; m0_writedata = 32'hCAFEF00D;
    @(negedge clk);
    check("t4_wr_wait0", m0_waitrequest, 0);
    check("t4_wr_cs", mem_chipselect, 0);
    check("t4_wr_memwr", mem_write, 0);
    next_cycle();
    idle_all();
    m0_read = 1'b1; m0_address = 14'd16383;
    @(negedge clk);
    check("t4_rd_wait0", m0_waitrequest, 0);
    check("t4_rd_cs", mem_chipselect, 0);
    expect_read(1'b0, 32'hDEADBEEF);
    next_cycle();
    idle_all();
    next_cycle();
    check("t4_dropped", ram[10240], 32'h0);

    // Read accepted, then reset on the following cycle: no return.
    m0_read = 1'b1; m0_address = 14'd5;
    @(negedge clk);
    check("t5_wait0", m0_waitrequest, 0);
    next_cycle();
    reset_n = 1'b0;
    m0_read = 1'b1; m0_address = 14'd20;
    m1_read = 1'b1; m1_address = 14'd40;
    @(negedge clk);
    check("t5_rdv0", m0_readdatavalid, 0);
    check("t5_rst_wait0", m0_waitrequest, 1);
    check("t5_rst_wait1", m1_waitrequest, 1);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;

    // Continuous contention straight out of reset: strict alternation starting with m0.
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      w = (k % 2 == 1);
      check("t2_wait0", m0_waitrequest, w);
      check("t2_wait1", m1_waitrequest, !w);
      expect_read(w, w ? 32'h10000028 : 32'h10000014);
    end
    next_cycle();
    idle_all();

`ifdef DIRCC_MEM_ARB_LOCK_EN
    // m0 locks while m1 requests every cycle: m1 waits 16 cycles, wins the 17th.
    m0_lock = 1'b1; m0_read = 1'b1; m0_address = 14'd5;
    m1_read = 1'b1; m1_address = 14'd40;
    for (int k = 0; k < 17; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      w = (k == 16);
      check("lk_wait0", m0_waitrequest, w);
      check("lk_wait1", m1_waitrequest, !w);
      expect_read(w, w ? 32'h10000028 : 32'h12345678);
    end
    next_cycle();
    idle_all();
`endif

    repeat (3) next_cycle();
    check("end_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
